// File: rtl/rename_map_pkg.sv
// Shared widths, tag/map types and the map read helper for the register alias table.
package rename_map_pkg;
    localparam int ARCH_REG_NUM = 32;
    localparam int ARCH_REG_SEL = 5;
    localparam int PHY_REG_NUM  = 64;
    localparam int PHY_REG_SEL  = 6;

    typedef logic [ARCH_REG_SEL-1:0] arch_t;
    typedef logic [PHY_REG_SEL-1:0]  tag_t;
    typedef tag_t [ARCH_REG_NUM-1:0] map_t;

    // r0 is hardwired: it always reads as tag 0 whatever the table holds.
    function automatic tag_t map_lookup(input map_t m, input arch_t a);
        return (a == '0) ? '0 : m[a];
    endfunction
endpackage

// File: rtl/rename_map_map_table.sv
// Architectural-to-physical map: four read ports, two ordered write ports
// (port 2 wins), and a bulk load that overrides both writes.
module map_table
    import rename_map_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  arch_t rd_addr_0,
    input  arch_t rd_addr_1,
    input  arch_t rd_addr_2,
    input  arch_t rd_addr_3,
    output tag_t  rd_data_0,
    output tag_t  rd_data_1,
    output tag_t  rd_data_2,
    output tag_t  rd_data_3,
    input  logic  wr_en_1,
    input  arch_t wr_addr_1,
    input  tag_t  wr_data_1,
    input  logic  wr_en_2,
    input  arch_t wr_addr_2,
    input  tag_t  wr_data_2,
    input  logic  load_en,
    input  map_t  load_map,
    output map_t  map_cur,
    output map_t  map_next
);
    map_t map_q;

    always_comb begin
        map_next = map_q;
        if (load_en) begin
            map_next = load_map;
        end else begin
            if (wr_en_1 && wr_addr_1 != '0) map_next[wr_addr_1] = wr_data_1;
            if (wr_en_2 && wr_addr_2 != '0) map_next[wr_addr_2] = wr_data_2;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ARCH_REG_NUM; i++) map_q[i] <= PHY_REG_SEL'(i);
        end else begin
            map_q <= map_next;
        end
    end

    assign map_cur   = map_q;
    assign rd_data_0 = map_lookup(map_q, rd_addr_0);
    assign rd_data_1 = map_lookup(map_q, rd_addr_1);
    assign rd_data_2 = map_lookup(map_q, rd_addr_2);
    assign rd_data_3 = map_lookup(map_q, rd_addr_3);
endmodule

// File: rtl/rename_map.sv
// Two-wide register alias table: speculative map with intra-group bypass,
// committed map restored into the speculative map on misprediction.
module rename_map
    import rename_map_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  inst1_valid,
    input  logic  inst2_valid,
    input  arch_t src1_1,
    input  arch_t src2_1,
    input  arch_t src1_2,
    input  arch_t src2_2,
    input  arch_t dst_1,
    input  arch_t dst_2,
    input  logic  wr_reg_1,
    input  logic  wr_reg_2,
    input  tag_t  phy_dst1,
    input  tag_t  phy_dst2,
    input  logic  phy_dst1_valid,
    input  logic  phy_dst2_valid,
    input  logic  allocatable,
    input  logic  stall_DP,
    input  logic  prmiss,
    input  logic  com1_val,
    input  logic  com2_val,
    input  arch_t com_dst1,
    input  arch_t com_dst2,
    input  tag_t  com_phy1,
    input  tag_t  com_phy2,
    output tag_t  rn_src1_1,
    output tag_t  rn_src2_1,
    output tag_t  rn_src1_2,
    output tag_t  rn_src2_2,
    output tag_t  rn_dst1,
    output tag_t  rn_dst2,
    output tag_t  rn_old1,
    output tag_t  rn_old2,
    output logic  rn_wr1,
    output logic  rn_wr2,
    output logic  rn_valid1,
    output logic  rn_valid2
);
    logic fire, wr1, wr2;
    tag_t map_s11, map_s21, map_s12, map_s22;
    tag_t lk_s11, lk_s21, lk_s12, lk_s22, lk_old1, lk_old2;
    map_t smap_cur, cmap_next;
    map_t smap_next_unused, cmap_cur_unused;
    tag_t cmap_rd0_unused, cmap_rd1_unused, cmap_rd2_unused, cmap_rd3_unused;

    assign fire = allocatable && !stall_DP && !prmiss;
    assign wr1  = inst1_valid && wr_reg_1 && (dst_1 != '0);
    assign wr2  = inst2_valid && wr_reg_2 && (dst_2 != '0);

    map_table u_smap (
        .clk       (clk),          .reset     (reset),
        .rd_addr_0 (src1_1),       .rd_addr_1 (src2_1),
        .rd_addr_2 (src1_2),       .rd_addr_3 (src2_2),
        .rd_data_0 (map_s11),      .rd_data_1 (map_s21),
        .rd_data_2 (map_s12),      .rd_data_3 (map_s22),
        .wr_en_1   (fire && wr1),  .wr_addr_1 (dst_1),  .wr_data_1 (phy_dst1),
        .wr_en_2   (fire && wr2),  .wr_addr_2 (dst_2),  .wr_data_2 (phy_dst2),
        .load_en   (prmiss),       .load_map  (cmap_next),
        .map_cur   (smap_cur),     .map_next  (smap_next_unused)
    );

    // Committed map never bulk-loads; its post-commit contents feed the flush.
    map_table u_cmap (
        .clk       (clk),             .reset     (reset),
        .rd_addr_0 ('0),              .rd_addr_1 ('0),
        .rd_addr_2 ('0),              .rd_addr_3 ('0),
        .rd_data_0 (cmap_rd0_unused), .rd_data_1 (cmap_rd1_unused),
        .rd_data_2 (cmap_rd2_unused), .rd_data_3 (cmap_rd3_unused),
        .wr_en_1   (com1_val),        .wr_addr_1 (com_dst1), .wr_data_1 (com_phy1),
        .wr_en_2   (com2_val),        .wr_addr_2 (com_dst2), .wr_data_2 (com_phy2),
        .load_en   (1'b0),            .load_map  ('0),
        .map_cur   (cmap_cur_unused), .map_next  (cmap_next)
    );

    always_comb begin
        lk_s11  = map_s11;
        lk_s21  = map_s21;
        lk_s12  = (wr1 && src1_2 == dst_1 && src1_2 != '0) ? phy_dst1 : map_s12;
        lk_s22  = (wr1 && src2_2 == dst_1 && src2_2 != '0) ? phy_dst1 : map_s22;
        lk_old1 = map_lookup(smap_cur, dst_1);
        lk_old2 = (wr1 && dst_2 == dst_1) ? phy_dst1 : map_lookup(smap_cur, dst_2);
    end

    // Output register stage: flush beats stall, stall beats bubble.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            rn_src1_1 <= '0;  rn_src2_1 <= '0;
            rn_src1_2 <= '0;  rn_src2_2 <= '0;
            rn_dst1   <= '0;  rn_dst2   <= '0;
            rn_old1   <= '0;  rn_old2   <= '0;
            rn_wr1    <= 1'b0; rn_wr2    <= 1'b0;
            rn_valid1 <= 1'b0; rn_valid2 <= 1'b0;
        end else if (prmiss || (!stall_DP && !allocatable)) begin
            rn_wr1    <= 1'b0; rn_wr2    <= 1'b0;
            rn_valid1 <= 1'b0; rn_valid2 <= 1'b0;
        end else if (fire) begin
            rn_src1_1 <= lk_s11;
            rn_src2_1 <= lk_s21;
            rn_src1_2 <= lk_s12;
            rn_src2_2 <= lk_s22;
            rn_dst1   <= wr1 ? phy_dst1 : '0;
            rn_dst2   <= wr2 ? phy_dst2 : '0;
            rn_old1   <= wr1 ? lk_old1 : '0;
            rn_old2   <= wr2 ? lk_old2 : '0;
            rn_wr1    <= wr1;
            rn_wr2    <= wr2;
            rn_valid1 <= inst1_valid;
            rn_valid2 <= inst2_valid;
        end
    end
endmodule

// File: tb/tb_rename_map.sv
// Directed bench for rename_map: inputs driven at posedge, outputs checked at
// the following posedge (state updates on negedge).
module tb_rename_map;
    import rename_map_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  inst1_valid, inst2_valid;
    arch_t src1_1, src2_1, src1_2, src2_2, dst_1, dst_2;
    logic  wr_reg_1, wr_reg_2;
    tag_t  phy_dst1, phy_dst2;
    logic  phy_dst1_valid, phy_dst2_valid;
    logic  allocatable, stall_DP, prmiss;
    logic  com1_val, com2_val;
    arch_t com_dst1, com_dst2;
    tag_t  com_phy1, com_phy2;
    tag_t  rn_src1_1, rn_src2_1, rn_src1_2, rn_src2_2;
    tag_t  rn_dst1, rn_dst2, rn_old1, rn_old2;
    logic  rn_wr1, rn_wr2, rn_valid1, rn_valid2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rename_map dut (
        .clk(clk), .reset(reset),
        .inst1_valid(inst1_valid), .inst2_valid(inst2_valid),
        .src1_1(src1_1), .src2_1(src2_1), .src1_2(src1_2), .src2_2(src2_2),
        .dst_1(dst_1), .dst_2(dst_2), .wr_reg_1(wr_reg_1), .wr_reg_2(wr_reg_2),
        .phy_dst1(phy_dst1), .phy_dst2(phy_dst2),
        .phy_dst1_valid(phy_dst1_valid), .phy_dst2_valid(phy_dst2_valid),
        .allocatable(allocatable), .stall_DP(stall_DP), .prmiss(prmiss),
        .com1_val(com1_val), .com2_val(com2_val),
        .com_dst1(com_dst1), .com_dst2(com_dst2),
        .com_phy1(com_phy1), .com_phy2(com_phy2),
        .rn_src1_1(rn_src1_1), .rn_src2_1(rn_src2_1),
        .rn_src1_2(rn_src1_2), .rn_src2_2(rn_src2_2),
        .rn_dst1(rn_dst1), .rn_dst2(rn_dst2),
        .rn_old1(rn_old1), .rn_old2(rn_old2),
        .rn_wr1(rn_wr1), .rn_wr2(rn_wr2),
        .rn_valid1(rn_valid1), .rn_valid2(rn_valid2)
    );

    // Free-list precondition: a writing slot always carries a valid tag.
    always @(negedge clk) begin
        if (reset && allocatable && !stall_DP && !prmiss) begin
            assert (!(inst1_valid && wr_reg_1 && dst_1 != '0) || phy_dst1_valid)
                else $error("phy_dst1_valid low on writing slot 1");
            assert (!(inst2_valid && wr_reg_2 && dst_2 != '0) || phy_dst2_valid)
                else $error("phy_dst2_valid low on writing slot 2");
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        inst1_valid = 0; inst2_valid = 0;
        src1_1 = 0; src2_1 = 0; src1_2 = 0; src2_2 = 0;
        dst_1 = 0; dst_2 = 0; wr_reg_1 = 0; wr_reg_2 = 0;
        phy_dst1 = 0; phy_dst2 = 0; phy_dst1_valid = 1; phy_dst2_valid = 1;
        allocatable = 1; stall_DP = 0; prmiss = 0;
        com1_val = 0; com2_val = 0; com_dst1 = 0; com_dst2 = 0;
        com_phy1 = 0; com_phy2 = 0;
    endtask

    // Apply the current inputs across one negedge, return at the next posedge.
    task automatic step();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic read4(input arch_t a, input arch_t b, input arch_t c, input arch_t d);
        idle();
        inst1_valid = 1; inst2_valid = 1;
        src1_1 = a; src2_1 = b; src1_2 = c; src2_2 = d;
        step();
    endtask

    initial begin
        idle();
        reset = 0;
        #12;
        chk("rst_valid1", int'(rn_valid1), 0);
        chk("rst_src1_1", int'(rn_src1_1), 0);
        chk("rst_old1",   int'(rn_old1),   0);
        @(posedge clk);
        reset = 1;

        // Plain lookup, no destination.
        idle();
        inst1_valid = 1; src1_1 = 3; src2_1 = 4;
        step();
        chk("id_src1_1", int'(rn_src1_1), 3);
        chk("id_src2_1", int'(rn_src2_1), 4);
        chk("id_valid1", int'(rn_valid1), 1);
        chk("id_wr1",    int'(rn_wr1),    0);
        chk("id_valid2", int'(rn_valid2), 0);

        // Slot 1 writes r5 -> 40, slot 2 reads r5 in the same group.
        idle();
        inst1_valid = 1; wr_reg_1 = 1; dst_1 = 5; phy_dst1 = 40;
        inst2_valid = 1; src1_2 = 5; src2_2 = 2;
        step();
        chk("byp_src1_2", int'(rn_src1_2), 40);
        chk("byp_src2_2", int'(rn_src2_2), 2);
        chk("byp_old1",   int'(rn_old1),   5);
        chk("byp_dst1",   int'(rn_dst1),   40);
        chk("byp_wr1",    int'(rn_wr1),    1);
        chk("byp_dst2",   int'(rn_dst2),   0);

        // Both slots write r7; slot 2 must win in the map.
        idle();
        inst1_valid = 1; wr_reg_1 = 1; dst_1 = 7; phy_dst1 = 41;
        inst2_valid = 1; wr_reg_2 = 1; dst_2 = 7; phy_dst2 = 42; src1_2 = 7;
        step();
        chk("ww_old1",   int'(rn_old1),   7);
        chk("ww_old2",   int'(rn_old2),   41);
        chk("ww_src1_2", int'(rn_src1_2), 41);
        chk("ww_dst2",   int'(rn_dst2),   42);
        chk("ww_wr2",    int'(rn_wr2),    1);
        read4(7, 5, 0, 1);
        chk("map_r7", int'(rn_src1_1), 42);
        chk("map_r5", int'(rn_src2_1), 40);
        chk("map_r0", int'(rn_src1_2), 0);

        // Stall three cycles with changing inputs: everything frozen.
        for (int i = 0; i < 3; i++) begin
            idle();
            stall_DP = 1;
            inst1_valid = 1; wr_reg_1 = 1; dst_1 = 9; phy_dst1 = tag_t'(50 + i);
            src1_1 = arch_t'(10 + i);
            step();
            chk("stall_src1_1", int'(rn_src1_1), 42);
            chk("stall_src2_1", int'(rn_src2_1), 40);
            chk("stall_valid1", int'(rn_valid1), 1);
            chk("stall_wr1",    int'(rn_wr1),    0);
        end
        read4(9, 10, 11, 12);
        chk("stall_map_r9", int'(rn_src1_1), 9);

        // Free list empty: bubble, map untouched.
        idle();
        allocatable = 0;
        inst1_valid = 1; wr_reg_1 = 1; dst_1 = 9; phy_dst1 = 60;
        step();
        chk("bub_valid1", int'(rn_valid1), 0);
        chk("bub_wr1",    int'(rn_wr1),    0);
        read4(9, 0, 0, 0);
        chk("bub_map_r9", int'(rn_src1_1), 9);

        // Commit r5->40, rename r5->50, then flush alongside commit r6->45.
        idle();
        com1_val = 1; com_dst1 = 5; com_phy1 = 40;
        step();
        idle();
        inst1_valid = 1; wr_reg_1 = 1; dst_1 = 5; phy_dst1 = 50;
        step();
        chk("pre_old1", int'(rn_old1), 40);
        idle();
        prmiss = 1; com1_val = 1; com_dst1 = 6; com_phy1 = 45;
        inst1_valid = 1; wr_reg_1 = 1; dst_1 = 8; phy_dst1 = 60;
        inst2_valid = 1;
        step();
        chk("fl_valid1", int'(rn_valid1), 0);
        chk("fl_valid2", int'(rn_valid2), 0);
        chk("fl_wr1",    int'(rn_wr1),    0);
        read4(5, 6, 7, 8);
        chk("fl_r5", int'(rn_src1_1), 40);
        chk("fl_r6", int'(rn_src2_1), 45);
        chk("fl_r7", int'(rn_src1_2), 7);
        chk("fl_r8", int'(rn_src2_2), 8);

        // Same-destination commits (slot 2 wins), r0 commit ignored, then flush.
        idle();
        com1_val = 1; com_dst1 = 10; com_phy1 = 20;
        com2_val = 1; com_dst2 = 10; com_phy2 = 21;
        step();
        idle();
        prmiss = 1; com1_val = 1; com_dst1 = 0; com_phy1 = 33;
        step();
        read4(10, 5, 0, 0);
        chk("cm_r10", int'(rn_src1_1), 21);
        chk("cm_r5",  int'(rn_src2_1), 40);

        // Destination r0 is never renamed.
        idle();
        inst1_valid = 1; wr_reg_1 = 1; dst_1 = 0; phy_dst1 = 55;
        inst2_valid = 1; src1_2 = 0;
        step();
        chk("r0_wr1",    int'(rn_wr1),    0);
        chk("r0_dst1",   int'(rn_dst1),   0);
        chk("r0_valid1", int'(rn_valid1), 1);
        chk("r0_src1_2", int'(rn_src1_2), 0);

        // Reset mid-stream clears outputs at once and restores identity.
        read4(10, 6, 0, 0);
        chk("mr_pre_src1_1", int'(rn_src1_1), 21);
        reset = 0;
        #1;
        chk("mr_valid1", int'(rn_valid1), 0);
        chk("mr_src1_1", int'(rn_src1_1), 0);
        chk("mr_src2_1", int'(rn_src2_1), 0);
        @(posedge clk);
        reset = 1;
        read4(10, 5, 0, 0);
        chk("mr_r10", int'(rn_src1_1), 10);
        chk("mr_r5",  int'(rn_src2_1), 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
